div_16_by_8: RTL

DIV_16_BY_8 -- requirements
Module: div_16_by_8

---
 rtl/div_pkg.sv | 19 +
 rtl/div_16_by_8_if.sv | 37 +++
 rtl/div_step.sv | 21 ++
 rtl/div_16_by_8.sv | 117 +++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared widths, iteration count and FSM state type for the 16-by-8 restoring divider.
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int REM_W      = DIVISOR_W + 1;
  localparam int ITER_N     = 16;
  localparam int CNT_W      = $clog2(ITER_N);

  localparam logic [CNT_W-1:0]      CNT_LAST      = CNT_W'(ITER_N - 1);
  localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_16_by_8_if.sv
// Request/result bundle for div_16_by_8; div_zero exists only when DIV_ZERO_FLAG_EN is defined.
interface div_16_by_8_if;
  import div_pkg::*;

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  busy;
  logic                  done;

`ifdef DIV_ZERO_FLAG_EN
  logic                  div_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done
  );
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module div_step
  import div_pkg::*;
(
  input  logic [REM_W-1:0]     rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     rem_out,
  output logic                 q_bit
);

  logic [REM_W-1:0] shifted;

  always_comb begin
    shifted = {rem_in[REM_W-2:0], bit_in};
    // a set top bit means the true shifted value is >= 512, above any divisor
    q_bit   = rem_in[REM_W-1] | (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/div_16_by_8.sv
// 16/8 unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional DIV_ZERO_FLAG_EN: adds div_zero and short-circuits divide-by-zero straight to DONE.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accepted start
// CALC  | 16 restoring iterations, busy high
// DONE  | one-cycle done pulse, results valid
module div_16_by_8
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  div_16_by_8_if.slave  bus
);

  state_t                state;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dsr;
  logic [REM_W-1:0]      rem;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  busy_q;
  logic                  done_q;
  logic [REM_W-1:0]      rem_next;
  logic                  q_bit;

  div_step u_step (
    .rem_in  (rem),
    .bit_in  (dvd[DIVIDEND_W-1]),
    .divisor (dsr),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

`ifdef DIV_ZERO_FLAG_EN
  logic div_zero_q;
  assign bus.div_zero = div_zero_q;
`endif

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd <= bus.dividend;
            dsr <= bus.divisor;
            rem <= '0;
            cnt <= '0;
`ifdef DIV_ZERO_FLAG_EN
            if (bus.divisor == '0) begin
              quotient_q  <= DIV0_QUOTIENT;
              remainder_q <= bus.dividend[DIVISOR_W-1:0];
              done_q      <= 1'b1;
              div_zero_q  <= 1'b1;
              state       <= DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= CALC;
            end
`else
            busy_q <= 1'b1;
            state  <= CALC;
`endif
          end
        end

        CALC: begin
          // dvd doubles as the quotient shift register: dividend bits leave the top, quotient bits enter the bottom
          dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
          rem <= rem_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            quotient_q  <= {dvd[DIVIDEND_W-2:0], q_bit};
            remainder_q <= rem_next[DIVISOR_W-1:0];
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          div_zero_q <= 1'b0;
`endif
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
